// File: rtl/booth_mul_seq_pkg.sv
// Shared constants and FSM state encoding for the sequential Booth multiplier.
// Combinational definitions only; no clocked behaviour lives here.
package booth_mul_seq_pkg;
  localparam int MUL_WIDTH   = 32;
  localparam int MUL_COUNT_W = 6;
  localparam int MUL_ITER    = 32;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;
endpackage

// File: rtl/addsub_32.sv
// 32-bit add/subtract from two cascaded cla_16; also reports the true 33-bit sign of the result.
// Combinational, zero latency; enable_add=0 passes a through unchanged.
module addsub_32
  import booth_mul_seq_pkg::*;
(
  input  logic [MUL_WIDTH-1:0] a,
  input  logic [MUL_WIDTH-1:0] b,
  input  logic                 sub,
  input  logic                 enable_add,
  output logic [MUL_WIDTH-1:0] sum,
  output logic                 cout,
  output logic                 sign
);
  logic [MUL_WIDTH-1:0] b_op;
  logic                 cin;
  logic                 c_mid;

  // Zeroing the operand on a no-add step makes sign collapse to a[31].
  assign b_op = enable_add ? (b ^ {MUL_WIDTH{sub}}) : '0;
  assign cin  = enable_add & sub;

  cla_16 u_cla_lo (
    .in_a     (a[15:0]),
    .in_b     (b_op[15:0]),
    .in_carry (cin),
    .out_sum  (sum[15:0]),
    .out_carry(c_mid)
  );

  cla_16 u_cla_hi (
    .in_a     (a[31:16]),
    .in_b     (b_op[31:16]),
    .in_carry (c_mid),
    .out_sum  (sum[31:16]),
    .out_carry(cout)
  );

  assign sign = a[31] ^ b_op[31] ^ cout;
endmodule

// File: rtl/cla_16.sv
// 16-bit carry-lookahead adder: 4-bit groups with a second lookahead level across groups.
// Purely combinational, zero latency, no flow control.
module cla_16 (
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_carry,
  output logic [15:0] out_sum,
  output logic        out_carry
);
  logic [15:0] g;
  logic [15:0] p;

  assign g = in_a & in_b;
  assign p = in_a ^ in_b;

  always_comb begin
    logic [3:0]  gg;
    logic [3:0]  pg;
    logic [4:0]  gc;
    logic [15:0] c;
    gg = '0;
    pg = '0;
    c  = '0;
    for (int i = 0; i < 4; i++) begin
      gg[i] = g[4*i+3] | (p[4*i+3] & g[4*i+2]) | (p[4*i+3] & p[4*i+2] & g[4*i+1])
            | (&p[4*i+1 +: 3] & g[4*i]);
      pg[i] = &p[4*i +: 4];
    end
    // Group carries are fully expanded so no group waits on its neighbour.
    gc[0] = in_carry;
    gc[1] = gg[0] | (pg[0] & gc[0]);
    gc[2] = gg[1] | (pg[1] & gg[0]) | (&pg[1:0] & gc[0]);
    gc[3] = gg[2] | (pg[2] & gg[1]) | (&pg[2:1] & gg[0]) | (&pg[2:0] & gc[0]);
    gc[4] = gg[3] | (pg[3] & gg[2]) | (&pg[3:2] & gg[1]) | (&pg[3:1] & gg[0])
          | (&pg[3:0] & gc[0]);
    for (int i = 0; i < 4; i++) begin
      c[4*i] = gc[i];
      for (int k = 0; k < 3; k++) begin
        c[4*i+k+1] = g[4*i+k] | (p[4*i+k] & c[4*i+k]);
      end
    end
    out_sum   = p ^ c;
    out_carry = gc[4];
  end
endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth signed multiplier, 32x32->64, one iteration per clock.
// Start accepted in IDLE/DONE only; out_done pulses in cycle 33 after the accepting edge.
module booth_mul_seq
  import booth_mul_seq_pkg::*;
#(
  parameter int WIDTH   = MUL_WIDTH,
  parameter int COUNT_W = MUL_COUNT_W
) (
  input  logic             in_clk,
  input  logic             in_reset_n,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo
);
  mul_state_e         state, state_nxt;
  logic [WIDTH-1:0]   a_r, a_nxt;
  logic [WIDTH-1:0]   q_r, q_nxt;
  logic [WIDTH-1:0]   m_r, m_nxt;
  logic               q1_r, q1_nxt;
  logic [COUNT_W-1:0] cnt_r, cnt_nxt;
  logic [WIDTH-1:0]   hi_nxt, lo_nxt;
  logic [WIDTH-1:0]   add_sum;
  logic               add_sign;
  logic               unused_cout;

  addsub_32 u_addsub (
    .a         (a_r),
    .b         (m_r),
    .sub       (q_r[0]),
    .enable_add(q_r[0] ^ q1_r),
    .sum       (add_sum),
    .cout      (unused_cout),
    .sign      (add_sign)
  );

  always_comb begin
    state_nxt = state;
    a_nxt     = a_r;
    q_nxt     = q_r;
    m_nxt     = m_r;
    q1_nxt    = q1_r;
    cnt_nxt   = cnt_r;
    hi_nxt    = out_hi;
    lo_nxt    = out_lo;
    case (state)
      MUL_RUN: begin
        a_nxt   = {add_sign, add_sum[WIDTH-1:1]};
        q_nxt   = {add_sum[0], q_r[WIDTH-1:1]};
        q1_nxt  = q_r[0];
        cnt_nxt = cnt_r + 1'b1;
        if (cnt_r == COUNT_W'(MUL_ITER - 1)) begin
          state_nxt = MUL_DONE;
          hi_nxt    = a_nxt;
          lo_nxt    = q_nxt;
        end
      end
      default: begin
        // IDLE and DONE both accept a new operation, giving back-to-back issue.
        state_nxt = MUL_IDLE;
        if (in_start) begin
          state_nxt = MUL_RUN;
          m_nxt     = in_x;
          q_nxt     = in_y;
          a_nxt     = '0;
          q1_nxt    = 1'b0;
          cnt_nxt   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state  <= MUL_IDLE;
      a_r    <= '0;
      q_r    <= '0;
      m_r    <= '0;
      q1_r   <= 1'b0;
      cnt_r  <= '0;
      out_hi <= '0;
      out_lo <= '0;
    end else begin
      state  <= state_nxt;
      a_r    <= a_nxt;
      q_r    <= q_nxt;
      m_r    <= m_nxt;
      q1_r   <= q1_nxt;
      cnt_r  <= cnt_nxt;
      out_hi <= hi_nxt;
      out_lo <= lo_nxt;
    end
  end

  assign out_busy = (state == MUL_RUN);
  assign out_done = (state == MUL_DONE);
endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench for booth_mul_seq: driver queues expected products, monitor checks each done pulse.
module tb_booth_mul_seq;
  logic        in_clk;
  logic        in_reset_n;
  logic        in_start;
  logic [31:0] in_x;
  logic [31:0] in_y;
  logic        out_busy;
  logic        out_done;
  logic [31:0] out_hi;
  logic [31:0] out_lo;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int overlap  = 0;
  logic [63:0] exp_q[$];

  booth_mul_seq dut (
    .in_clk    (in_clk),
    .in_reset_n(in_reset_n),
    .in_start  (in_start),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_busy  (out_busy),
    .out_done  (out_done),
    .out_hi    (out_hi),
    .out_lo    (out_lo)
  );

  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic [63:0] exp);
    @(negedge in_clk);
    in_x     = x;
    in_y     = y;
    in_start = 1'b1;
    exp_q.push_back(exp);
    @(posedge in_clk);
    #1 in_start = 1'b0;
  endtask

  // Returns the number of negedges (cycles) until out_done, or -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge in_clk);
      if (out_done) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done expected done within 100 cycles");
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse and tracks busy length.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge in_clk);
      if (!in_reset_n) begin
        busy_cnt = 0;
      end else begin
        if (out_busy && out_done) overlap++;
        if (out_busy) busy_cnt++;
        if (out_done) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got hi=%h lo=%h expected no result", out_hi, out_lo);
          end else begin
            e = exp_q.pop_front();
            chk("result_hi", {32'h0, out_hi}, {32'h0, e[63:32]});
            chk("result_lo", {32'h0, out_lo}, {32'h0, e[31:0]});
            chk("busy_cycles", 64'(busy_cnt), 64'd32);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  initial begin
    int lat;
    int d0;
    in_reset_n = 1'b1;
    in_start   = 1'b0;
    in_x       = '0;
    in_y       = '0;
    #1 in_reset_n = 1'b0;
    #2;
    chk("reset_busy", {63'h0, out_busy}, 64'h0);
    chk("reset_done", {63'h0, out_done}, 64'h0);
    chk("reset_hi", {32'h0, out_hi}, 64'h0);
    chk("reset_lo", {32'h0, out_lo}, 64'h0);
    repeat (2) @(negedge in_clk);
    in_reset_n = 1'b1;

    start_op(32'd3, 32'd5, 64'h0000_0000_0000_000F);
    wait_done(lat);
    chk("latency_3x5", 64'(lat), 64'd33);

    start_op(32'hFFFF_FFFF, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done(lat);
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    wait_done(lat);
    start_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    wait_done(lat);
    start_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
    wait_done(lat);
    start_op(32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000);
    wait_done(lat);

    // Start request during RUN must be dropped.
    start_op(32'd6, 32'd7, 64'h0000_0000_0000_002A);
    repeat (9) @(negedge in_clk);
    in_x     = 32'd9;
    in_y     = 32'd9;
    in_start = 1'b1;
    @(posedge in_clk);
    #1 in_start = 1'b0;
    d0 = done_cnt;
    wait_done(lat);
    repeat (40) @(negedge in_clk);
    chk("ignored_start_done_count", 64'(done_cnt), 64'(d0 + 1));

    // Reset mid-RUN clears everything immediately and discards the result.
    start_op(32'd12, 32'd12, 64'h0000_0000_0000_0090);
    repeat (14) @(negedge in_clk);
    @(posedge in_clk);
    #2 in_reset_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    chk("midrun_reset_busy", {63'h0, out_busy}, 64'h0);
    chk("midrun_reset_done", {63'h0, out_done}, 64'h0);
    chk("midrun_reset_hi", {32'h0, out_hi}, 64'h0);
    chk("midrun_reset_lo", {32'h0, out_lo}, 64'h0);
    repeat (2) @(negedge in_clk);
    in_reset_n = 1'b1;
    start_op(32'd2, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFA);
    wait_done(lat);
    chk("latency_after_reset", 64'(lat), 64'd33);

    // Back-to-back: new start presented in the DONE cycle.
    start_op(32'd4, 32'd4, 64'h0000_0000_0000_0010);
    wait_done(lat);
    in_x     = 32'h0001_0000;
    in_y     = 32'h0001_0000;
    in_start = 1'b1;
    exp_q.push_back(64'h0000_0001_0000_0000);
    @(posedge in_clk);
    #1 in_start = 1'b0;
    repeat (16) @(negedge in_clk);
    chk("hold_during_run", {out_hi, out_lo}, 64'h0000_0000_0000_0010);
    chk("busy_mid_b2b", {63'h0, out_busy}, 64'h1);
    wait_done(lat);
    chk("latency_b2b", 64'(lat + 16), 64'd33);

    repeat (5) @(negedge in_clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("busy_done_overlap", 64'(overlap), 64'd0);
    chk("total_done_count", 64'(done_cnt), 64'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
